// File: rtl/fpga_cfg_pkg.sv
// Shared definitions for the CLB configuration loader.
//   CLB_CFG_W      : config bits per CLB
//   CFG_MAGIC      : frame start byte
//   *_LSB / *_W    : field layout inside one CLB config word
//   cfg_state_e    : loader FSM states
package fpga_cfg_pkg;

    localparam int          CLB_CFG_W = 13;
    localparam logic [7:0]  CFG_MAGIC = 8'hA5;

    // CLB config word layout
    localparam int MODE_LSB   = 0;
    localparam int MODE_W     = 2;
    localparam int ASEL_LSB   = 2;
    localparam int ASEL_W     = 3;
    localparam int BSEL_LSB   = 5;
    localparam int BSEL_W     = 3;
    localparam int ROUTE_LSB  = 8;
    localparam int ROUTE_W    = 4;
    localparam int USEFF_LSB  = 12;
    localparam int USEFF_W    = 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_CHECK = 2'd2,
        ST_DONE  = 2'd3
    } cfg_state_e;

    // Payload bytes needed to carry tot_w config bits.
    function automatic int cfg_nbytes(input int tot_w);
        return (tot_w + 7) / 8;
    endfunction

endpackage

// File: rtl/fpga_cfg_loader.sv
// Byte-stream configuration loader for the CLB array.
// Frame: MAGIC, NBYTES payload bytes (LSB first), XOR checksum of payload.
// The frame is built in a shadow register and copied to the active config
// in one cycle only when the checksum matches, so cfg_o never shows a
// partial or corrupt frame.
// Ports:
//   clk_i, rst_ni          clock, async active-low reset
//   in_data_i/valid/ready  byte stream in (transfer = valid & ready)
//   abort_i                sync abort of the frame in progress
//   cfg_o                  active config, CLB k at cfg_o[k*13 +: 13]
//   cfg_valid_o            set after the first successful commit
//   busy_o                 FSM not idle
//   done_o                 one-cycle pulse after a commit
//   err_o                  sticky checksum error, cleared by next MAGIC
module fpga_cfg_loader
    import fpga_cfg_pkg::*;
#(
    parameter int NUM_CLB = 4
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic [7:0]                     in_data_i,
    input  logic                           in_valid_i,
    output logic                           in_ready_o,
    input  logic                           abort_i,
    output logic [NUM_CLB*CLB_CFG_W-1:0]   cfg_o,
    output logic                           cfg_valid_o,
    output logic                           busy_o,
    output logic                           done_o,
    output logic                           err_o
);

    localparam int TOT_W  = NUM_CLB * CLB_CFG_W;
    localparam int NBYTES = cfg_nbytes(TOT_W);
    localparam int SH_W   = NBYTES * 8;
    localparam int CNT_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NBYTES - 1);

    cfg_state_e         state_q, state_d;
    logic [CNT_W-1:0]   byte_cnt_q, byte_cnt_d;
    logic [7:0]         csum_q, csum_d;
    logic [SH_W-1:0]    shadow_q, shadow_d;
    logic [TOT_W-1:0]   cfg_q, cfg_d;
    logic               cfg_valid_q, cfg_valid_d;
    logic               err_q, err_d;

    logic               ready;
    logic               accept;
    logic               csum_ok;
    logic               shadow_pad_unused;

    assign accept  = in_valid_i & ready;
    assign csum_ok = (in_data_i == csum_q);

    // Pad bits above TOT_W are stored but never reach the CLBs.
    assign shadow_pad_unused = ^shadow_q;

    // ---------------- state register + datapath flops ----------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            byte_cnt_q  <= '0;
            csum_q      <= '0;
            shadow_q    <= '0;
            cfg_q       <= '0;
            cfg_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            byte_cnt_q  <= byte_cnt_d;
            csum_q      <= csum_d;
            shadow_q    <= shadow_d;
            cfg_q       <= cfg_d;
            cfg_valid_q <= cfg_valid_d;
            err_q       <= err_d;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d = state_q;
        if (abort_i) begin
            // DONE also falls back to IDLE; the commit already happened.
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE:  if (accept && in_data_i == CFG_MAGIC) state_d = ST_LOAD;
                ST_LOAD:  if (accept && byte_cnt_q == LAST_IDX) state_d = ST_CHECK;
                ST_CHECK: if (accept) state_d = csum_ok ? ST_DONE : ST_IDLE;
                ST_DONE:  state_d = ST_IDLE;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    // ---------------- datapath next values ----------------
    always_comb begin
        byte_cnt_d  = byte_cnt_q;
        csum_d      = csum_q;
        shadow_d    = shadow_q;
        cfg_d       = cfg_q;
        cfg_valid_d = cfg_valid_q;
        err_d       = err_q;
        if (abort_i) begin
            // Active config and the error flag survive an abort.
            byte_cnt_d = '0;
            csum_d     = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (accept && in_data_i == CFG_MAGIC) begin
                        byte_cnt_d = '0;
                        csum_d     = '0;
                        err_d      = 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (accept) begin
                        for (int i = 0; i < NBYTES; i++) begin
                            if (byte_cnt_q == CNT_W'(i)) shadow_d[i*8 +: 8] = in_data_i;
                        end
                        csum_d     = csum_q ^ in_data_i;
                        byte_cnt_d = byte_cnt_q + 1'b1;
                    end
                end
                ST_CHECK: begin
                    if (accept) begin
                        if (csum_ok) begin
                            cfg_d       = shadow_q[TOT_W-1:0];
                            cfg_valid_d = 1'b1;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // ---------------- outputs ----------------
    always_comb begin
        ready       = !abort_i && (state_q != ST_DONE);
        in_ready_o  = ready;
        busy_o      = (state_q != ST_IDLE);
        done_o      = (state_q == ST_DONE);
        cfg_o       = cfg_q;
        cfg_valid_o = cfg_valid_q;
        err_o       = err_q;
    end

endmodule

// File: tb/tb_fpga_cfg_loader.sv
module tb_fpga_cfg_loader;
    import fpga_cfg_pkg::*;

    localparam int NUM_CLB = 4;
    localparam int TOT_W   = NUM_CLB * CLB_CFG_W;
    localparam int NB      = (TOT_W + 7) / 8;

    logic               clk_i = 1'b0;
    logic               rst_ni = 1'b1;
    logic [7:0]         in_data_i = 8'h00;
    logic               in_valid_i = 1'b0;
    logic               in_ready_o;
    logic               abort_i = 1'b0;
    logic [TOT_W-1:0]   cfg_o;
    logic               cfg_valid_o;
    logic               busy_o;
    logic               done_o;
    logic               err_o;

    fpga_cfg_loader #(.NUM_CLB(NUM_CLB)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .in_data_i   (in_data_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .abort_i     (abort_i),
        .cfg_o       (cfg_o),
        .cfg_valid_o (cfg_valid_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .err_o       (err_o)
    );

    always #5 clk_i = ~clk_i;

    int nchk = 0;
    int nerr = 0;
    int last_wait = 0;

    // Transaction-level model: what the CLBs should currently see.
    logic [TOT_W-1:0] exp_cfg = '0;
    logic             exp_valid = 1'b0;
    logic             exp_err = 1'b0;
    logic [7:0]       pay [NB];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [TOT_W-1:0] pack_pay();
        logic [NB*8-1:0] f;
        f = '0;
        for (int k = 0; k < NB; k++) f[8*k +: 8] = pay[k];
        return f[TOT_W-1:0];
    endfunction

    function automatic logic [7:0] xor_pay();
        logic [7:0] x;
        x = 8'h00;
        for (int k = 0; k < NB; k++) x ^= pay[k];
        return x;
    endfunction

    // Called at a negedge; returns at the negedge after the byte transferred.
    task automatic put(input logic [7:0] b, input int gmax);
        int n;
        int g;
        g = (gmax > 0) ? $urandom_range(0, gmax) : 0;
        in_valid_i = 1'b0;
        for (int i = 0; i < g; i++) @(negedge clk_i);
        in_data_i  = b;
        in_valid_i = 1'b1;
        n = 0;
        while (!in_ready_o && n < 50) begin
            @(negedge clk_i);
            n++;
        end
        if (n >= 50) chk("ready_timeout", {63'd0, in_ready_o}, 64'd1);
        last_wait = n;
        @(negedge clk_i);
        in_valid_i = 1'b0;
    endtask

    // Send MAGIC + pay[] + checksum and check the outcome.
    task automatic frame(input int gmax, input logic tail, input logic force_cs, input logic [7:0] cs_val);
        logic [7:0] cs;
        logic       good;
        cs   = force_cs ? cs_val : xor_pay();
        good = (cs == xor_pay());
        put(CFG_MAGIC, gmax);
        for (int k = 0; k < NB; k++) put(pay[k], gmax);
        put(cs, gmax);
        if (good) begin
            exp_cfg   = pack_pay();
            exp_valid = 1'b1;
            exp_err   = 1'b0;
            chk("done_hi", {63'd0, done_o}, 64'd1);
            chk("ready_in_done", {63'd0, in_ready_o}, 64'd0);
        end else begin
            exp_err = 1'b1;
            chk("done_lo_bad", {63'd0, done_o}, 64'd0);
            chk("busy_after_bad", {63'd0, busy_o}, 64'd0);
        end
        chk("cfg", 64'(cfg_o), 64'(exp_cfg));
        chk("cfg_valid", {63'd0, cfg_valid_o}, {63'd0, exp_valid});
        chk("err", {63'd0, err_o}, {63'd0, exp_err});
        if (good && tail) begin
            @(negedge clk_i);
            chk("done_pulse_end", {63'd0, done_o}, 64'd0);
            chk("cfg_hold", 64'(cfg_o), 64'(exp_cfg));
        end
    endtask

    initial begin
        logic [7:0] g;
        // ---- reset ----
        #2 rst_ni = 1'b0;
        #1;
        chk("rst_cfg", 64'(cfg_o), 64'd0);
        chk("rst_valid", {63'd0, cfg_valid_o}, 64'd0);
        chk("rst_busy", {63'd0, busy_o}, 64'd0);
        chk("rst_done", {63'd0, done_o}, 64'd0);
        chk("rst_err", {63'd0, err_o}, 64'd0);
        @(negedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);

        // ---- directed good frame ----
        for (int k = 0; k < NB; k++) pay[k] = 8'(k + 1);
        frame(0, 1'b1, 1'b0, 8'h00);
        chk("cfg_const", 64'(cfg_o), 64'h7_0605_0403_0201);
        chk("clb0_word", 64'(cfg_o[CLB_CFG_W-1:0]), 64'h0201);

        // ---- bad checksum, then good frame clears err ----
        frame(0, 1'b1, 1'b1, 8'hFF);
        put(CFG_MAGIC, 0);
        chk("err_clr_magic", {63'd0, err_o}, 64'd0);
        chk("busy_load", {63'd0, busy_o}, 64'd1);
        for (int k = 0; k < NB; k++) put(pay[k], 0);
        put(xor_pay(), 0);
        exp_err = 1'b0;
        chk("done_after_recover", {63'd0, done_o}, 64'd1);
        @(negedge clk_i);

        // ---- garbage + stalls ----
        put(8'h3C, 0);
        chk("garbage_idle0", {63'd0, busy_o}, 64'd0);
        put(8'h00, 0);
        chk("garbage_idle1", {63'd0, busy_o}, 64'd0);
        for (int k = 0; k < NB; k++) pay[k] = 8'($urandom_range(0, 255));
        frame(3, 1'b1, 1'b0, 8'h00);

        // ---- abort after 3 payload bytes ----
        for (int k = 0; k < NB; k++) pay[k] = 8'($urandom_range(0, 255));
        put(CFG_MAGIC, 0);
        for (int k = 0; k < 3; k++) put(pay[k], 0);
        in_data_i  = pay[3];
        in_valid_i = 1'b1;
        abort_i    = 1'b1;
        #1;
        chk("abort_ready", {63'd0, in_ready_o}, 64'd0);
        @(negedge clk_i);
        abort_i    = 1'b0;
        in_valid_i = 1'b0;
        chk("abort_busy", {63'd0, busy_o}, 64'd0);
        chk("abort_cfg", 64'(cfg_o), 64'(exp_cfg));
        chk("abort_valid", {63'd0, cfg_valid_o}, {63'd0, exp_valid});
        frame(1, 1'b1, 1'b0, 8'h00);

        // ---- DONE backpressure: next MAGIC held through DONE ----
        for (int k = 0; k < NB; k++) pay[k] = 8'($urandom_range(0, 255));
        frame(0, 1'b0, 1'b0, 8'h00);
        put(CFG_MAGIC, 0);
        chk("bp_wait_cycles", 64'(last_wait), 64'd1);
        chk("bp_busy", {63'd0, busy_o}, 64'd1);
        for (int k = 0; k < NB; k++) put(pay[k], 0);
        put(xor_pay(), 0);
        chk("bp_done", {63'd0, done_o}, 64'd1);
        chk("bp_cfg", 64'(cfg_o), 64'(pack_pay()));
        @(negedge clk_i);

        // ---- randomized frames ----
        for (int f = 0; f < 25; f++) begin
            int ng;
            ng = $urandom_range(0, 2);
            for (int i = 0; i < ng; i++) begin
                g = 8'($urandom_range(0, 255));
                if (g == CFG_MAGIC) g = 8'h5A;
                put(g, 1);
                chk("rnd_garbage_idle", {63'd0, busy_o}, 64'd0);
            end
            for (int k = 0; k < NB; k++) pay[k] = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 3) == 0)
                frame($urandom_range(0, 3), 1'b1, 1'b1, xor_pay() ^ 8'($urandom_range(1, 255)));
            else
                frame($urandom_range(0, 3), 1'b1, 1'b0, 8'h00);
        end

        // ---- reset mid-frame after a commit ----
        for (int k = 0; k < NB; k++) pay[k] = 8'($urandom_range(0, 255));
        frame(0, 1'b1, 1'b0, 8'h00);
        put(CFG_MAGIC, 0);
        for (int k = 0; k < 4; k++) put(pay[k], 0);
        #2 rst_ni = 1'b0;
        #1;
        exp_cfg   = '0;
        exp_valid = 1'b0;
        exp_err   = 1'b0;
        chk("midrst_cfg", 64'(cfg_o), 64'(exp_cfg));
        chk("midrst_valid", {63'd0, cfg_valid_o}, 64'd0);
        chk("midrst_busy", {63'd0, busy_o}, 64'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        chk("midrst_idle", {63'd0, busy_o}, 64'd0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
